// File: rtl/ifid_pkg.sv
// ifid_pkg -- shared definitions for the IF/ID pipeline stage.
//
// Holds the default "no instruction" encoding and the entry record used by
// both the main and the skid register of ifid_pipe_stage.
//
// The entry record is sized for the widest supported datapath (64-bit PC,
// 64-bit instruction). The stage zero-extends narrower inputs into it and
// slices the outputs back down, so the upper bits are constant zero and
// disappear in synthesis. PC_W / INSTR_W above 64 are not supported.
package ifid_pkg;

    localparam int ENTRY_PC_W    = 64;
    localparam int ENTRY_INSTR_W = 64;

    // Encoding shown on instruction_out while the stage holds nothing.
    localparam logic [ENTRY_INSTR_W-1:0] IFID_NOP_INSTR = '0;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0]    pc;
        logic [ENTRY_INSTR_W-1:0] instr;
        logic                     valid;
    } ifid_entry_t;

    localparam ifid_entry_t IFID_EMPTY = '{pc: '0, instr: '0, valid: 1'b0};

    function automatic ifid_entry_t make_entry(
        input logic [ENTRY_PC_W-1:0]    pc,
        input logic [ENTRY_INSTR_W-1:0] instr
    );
        ifid_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        e.valid = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/ifid_pipe_stage_sat_counter.sv
// sat_counter -- saturating up-counter with asynchronous active-high reset.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous reset, active high; clears the count
//   en     in   increment this cycle
//   count  out  CNT_W  current count; holds at all-ones once reached
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ifid_pipe_stage.sv
// ifid_pipe_stage -- IF/ID pipeline register with valid/ready handshake.
//
// Carries PC+4 and the fetched instruction into decode. An entry is taken
// only when the cache reports a hit; decode consumes when stall is low;
// flush kills everything held (and anything arriving that cycle).
// bubble_cnt counts cycles ending with no valid entry, saturating.
//
// Build option: define IFID_SKID_EN to add a second (skid) entry so that
// in_ready is a pure register output with no path from stall. Without it
// the stage has a single entry and in_ready = !out_valid | !stall.
//
// Ports:
//   clk              in   clock, rising edge
//   rstn             in   asynchronous reset, ACTIVE HIGH despite the name
//   adder_in         in   PC_W     PC+4 from fetch
//   instruction_in   in   INSTR_W  instruction from fetch
//   in_valid         in   fetch presents an entry
//   hit              in   cache hit; entry ignored when 0
//   in_ready         out  stage can accept this cycle
//   stall            in   decode hold
//   flush            in   branch redirect, clears all entries
//   adder_out        out  PC_W     PC+4 to decode (0 when empty)
//   instruction_out  out  INSTR_W  instruction to decode (NOP_INSTR when empty)
//   out_valid        out  decode-side entry valid
//   bubble_cnt       out  CNT_W    saturating count of empty cycles
module ifid_pipe_stage
    import ifid_pkg::*;
#(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(IFID_NOP_INSTR),
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [PC_W-1:0]    adder_in,
    input  logic [INSTR_W-1:0] instruction_in,
    input  logic               in_valid,
    input  logic               hit,
    output logic               in_ready,
    input  logic               stall,
    input  logic               flush,
    output logic [PC_W-1:0]    adder_out,
    output logic [INSTR_W-1:0] instruction_out,
    output logic               out_valid,
    output logic [CNT_W-1:0]   bubble_cnt
);

    ifid_entry_t main_reg, main_next;
    ifid_entry_t incoming;
    logic        accept;
    logic        consume;
    logic        bubble_en;

    assign incoming = make_entry(ENTRY_PC_W'(adder_in), ENTRY_INSTR_W'(instruction_in));

`ifdef IFID_SKID_EN
    ifid_entry_t skid_reg, skid_next;
    logic        main_free;

    always_comb begin
        // Ready depends only on the skid register, never on stall.
        in_ready  = !skid_reg.valid;
        accept    = in_valid && hit && in_ready;
        consume   = main_reg.valid && !stall;
        main_free = !main_reg.valid || consume;
        main_next = main_reg;
        skid_next = skid_reg;
        if (flush) begin
            main_next = IFID_EMPTY;
            skid_next = IFID_EMPTY;
        end else if (main_free) begin
            // Skid is older than anything arriving, so it drains first.
            // With skid valid, accept is impossible (in_ready is low).
            if (skid_reg.valid) begin
                main_next = skid_reg;
                skid_next = IFID_EMPTY;
            end else if (accept) begin
                main_next = incoming;
            end else begin
                main_next = IFID_EMPTY;
            end
        end else if (accept) begin
            // Main is held by decode: park the new entry behind it.
            skid_next = incoming;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            skid_reg <= IFID_EMPTY;
        end else begin
            skid_reg <= skid_next;
        end
    end
`else
    always_comb begin
        in_ready  = !main_reg.valid || !stall;
        accept    = in_valid && hit && in_ready;
        consume   = main_reg.valid && !stall;
        main_next = main_reg;
        if (flush) begin
            main_next = IFID_EMPTY;
        end else if (accept) begin
            // in_ready guarantees main is empty or being consumed.
            main_next = incoming;
        end else if (consume) begin
            main_next = IFID_EMPTY;
        end
    end
`endif

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            main_reg <= IFID_EMPTY;
        end else begin
            main_reg <= main_next;
        end
    end

    // Mask the payload so decode never sees stale data from an old entry.
    assign out_valid       = main_reg.valid;
    assign adder_out       = main_reg.valid ? main_reg.pc[PC_W-1:0] : '0;
    assign instruction_out = main_reg.valid ? main_reg.instr[INSTR_W-1:0] : NOP_INSTR;

    // Count a bubble when the stage will be empty after this edge.
    assign bubble_en = !main_next.valid;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rstn),
        .en    (bubble_en),
        .count (bubble_cnt)
    );

    // Upper bits of the wide entry record are constant zero by design.
    logic unused_entry_bits;
    assign unused_entry_bits = ^{main_reg.pc, main_reg.instr};

endmodule

// File: tb/tb_ifid_pipe_stage.sv
module tb_ifid_pipe_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFID_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] adder_in;
    logic [31:0] instruction_in;
    logic        in_valid;
    logic        hit;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic [31:0] adder_out;
    logic [31:0] instruction_out;
    logic        out_valid;
    logic [3:0]  bubble_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    ifid_pipe_stage #(
        .PC_W      (32),
        .INSTR_W   (32),
        .NOP_INSTR (NOP),
        .CNT_W     (4)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .adder_in        (adder_in),
        .instruction_in  (instruction_in),
        .in_valid        (in_valid),
        .hit             (hit),
        .in_ready        (in_ready),
        .stall           (stall),
        .flush           (flush),
        .adder_out       (adder_out),
        .instruction_out (instruction_out),
        .out_valid       (out_valid),
        .bubble_cnt      (bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        stall;
        logic        in_valid;
        logic        hit;
        logic [31:0] adder;
        logic [31:0] instr;
        logic        exp_valid;
        logic [31:0] exp_adder;
        logic [31:0] exp_instr;
        logic        exp_ready;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fl, input logic st, input logic v, input logic h,
                         input logic [31:0] a, input logic [31:0] i);
        flush          = fl;
        stall          = st;
        in_valid       = v;
        hit            = h;
        adder_in       = a;
        instruction_in = i;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] a,
                           input logic [31:0] i);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, " adder_out"}, adder_out, a);
        chk({tag, " instruction_out"}, instruction_out, i);
    endtask

    initial begin
        //            flush stall v  hit adder          instr          | valid adder          instr          ready
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd2,        32'd3,        1'b1, 32'd2,        32'd3,        1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd200,      32'd300,      1'b0, 32'd0,        NOP,          1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h10,       32'h11,       1'b1, 32'h10,       32'h11,       1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h14,       32'h22,       1'b1, 32'h14,       32'h22,       1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h18,       32'h33,       1'b0, 32'd0,        NOP,          1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h99,       32'h98,       1'b0, 32'd0,        NOP,          1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1c,       32'h44,       1'b1, 32'h1c,       32'h44,       1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h20,       32'h55,       1'b0, 32'd0,        NOP,          1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd200,      32'd300,      1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, SKID};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        NOP,          1'b1};

        // Reset asserted from time 0 for 10 ns.
        rstn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #2;
        chk_out("reset", 1'b0, 32'd0, NOP);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset bubble_cnt", 32'(bubble_cnt), 32'd0);
        #8;
        rstn = 1'b0;
        step();
        chk("idle bubble_cnt 1", 32'(bubble_cnt), 32'd1);
        step();
        chk("idle bubble_cnt 2", 32'(bubble_cnt), 32'd2);

        // Table-driven vectors: apply, clock, compare.
        for (int k = 0; k < 11; k++) begin
            drive(vecs[k].flush, vecs[k].stall, vecs[k].in_valid, vecs[k].hit,
                  vecs[k].adder, vecs[k].instr);
            step();
            chk_out($sformatf("vec%0d", k), vecs[k].exp_valid, vecs[k].exp_adder, vecs[k].exp_instr);
            chk($sformatf("vec%0d in_ready", k), 32'(in_ready), 32'(vecs[k].exp_ready));
            $display("vec%0d: in a=%0h i=%0h v=%0b h=%0b st=%0b fl=%0b -> out v=%0b a=%0h i=%0h rdy=%0b",
                     k, vecs[k].adder, vecs[k].instr, vecs[k].in_valid, vecs[k].hit,
                     vecs[k].stall, vecs[k].flush, out_valid, adder_out, instruction_out, in_ready);
        end

        // Held entry A with a second entry B arriving under stall.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h41);
        step();
        chk_out("stallA load", 1'b1, 32'h40, 32'h41);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h44, 32'h45);
        #1;
        chk("stallA ready before B", 32'(in_ready), 32'(SKID));
        step();
        chk_out("stallA held", 1'b1, 32'h40, 32'h41);
        chk("stallA ready after B", 32'(in_ready), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("stallA ready release", 32'(in_ready), SKID ? 32'd0 : 32'd1);
        step();
        if (SKID) chk_out("stallA deliver B", 1'b1, 32'h44, 32'h45);
        else      chk_out("stallA B not taken", 1'b0, 32'd0, NOP);
        step();
        chk_out("stallA drained", 1'b0, 32'd0, NOP);
        $display("seq stall: A then %s", SKID ? "B delivered" : "B refused");

        // Flush with held entries and a new accept in the same cycle.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h50, 32'h51);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h54, 32'h55);
        step();
        chk_out("flush pre", 1'b1, 32'h50, 32'h51);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h60, 32'h61);
        step();
        chk_out("flush", 1'b0, 32'd0, NOP);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk_out("flush dropped", 1'b0, 32'd0, NOP);
        $display("seq flush: stage empty, C and B dropped");

        // Reset in the middle of operation acts immediately.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h70, 32'h71);
        step();
        chk_out("midrst pre", 1'b1, 32'h70, 32'h71);
        rstn = 1'b1;
        #1;
        chk_out("midrst", 1'b0, 32'd0, NOP);
        chk("midrst bubble_cnt", 32'(bubble_cnt), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        step();
        chk("midrst held bubble_cnt", 32'(bubble_cnt), 32'd0);
        rstn = 1'b0;
        $display("seq reset: outputs cleared immediately");

        // Counter from zero: counts, then saturates at 15.
        for (int c = 0; c < 3; c++) step();
        chk("sat bubble_cnt 3", 32'(bubble_cnt), 32'd3);
        for (int c = 0; c < 12; c++) step();
        chk("sat bubble_cnt 15", 32'(bubble_cnt), 32'd15);
        for (int c = 0; c < 5; c++) step();
        chk("sat bubble_cnt hold", 32'(bubble_cnt), 32'd15);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk("sat after flush", 32'(bubble_cnt), 32'd15);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        $display("seq counter: bubble_cnt=%0d", bubble_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifid_pipe_stage.md
# ifid_pipe_stage

Parametrised successor to the IF/ID pipeline register: carries the fetch-stage PC+4 and instruction into decode with a valid/ready handshake, cache-hit qualification, hazard stall, branch flush and a saturating bubble counter. Sits between the fetch stage (adder and instruction cache) and the decode stage. An optional two-entry skid buffer breaks the combinational path from `stall` to the fetch-stage ready.

## Interface
- `PC_W`, 32, width of the PC+4 (adder) path
- `INSTR_W`, 32, instruction width
- `NOP_INSTR`, 0, instruction driven while the stage holds no valid entry
- `CNT_W`, 16, bubble counter width

- `clk`  in  1  clock, rising edge
- `rstn`  in  1  asynchronous, active-high reset (asserted = 1)
- `adder_in`  in  PC_W  PC+4 from fetch
- `instruction_in`  in  INSTR_W  instruction from fetch
- `in_valid`  in  1  fetch presents an entry
- `hit`  in  1  instruction cache hit; entry is usable only when 1
- `in_ready`  out  1  stage can take an entry this cycle
- `stall`  in  1  decode hazard hold; decode consumes only when 0
- `flush`  in  1  branch redirect; kill all held entries
- `adder_out`  out  PC_W  PC+4 to decode
- `instruction_out`  out  INSTR_W  instruction to decode
- `out_valid`  out  1  decode-side entry valid
- `bubble_cnt`  out  CNT_W  cycles with `out_valid`=0 since reset

## Operation
- Accept = `in_valid` & `hit` & `in_ready`; `in_valid` with `hit`=0 is ignored and never stored.
- Consume = `out_valid` & !`stall`.
- Flush: at the clock edge, clears all entries; takes priority over accept and consume in the same cycle (an incoming entry is dropped).
- Main entry: on accept with main empty or consumed, load main; otherwise hold.
- While `out_valid`=0, `instruction_out`=`NOP_INSTR` and `adder_out`=0; they never show stale data.
- `bubble_cnt` increments each cycle that `out_valid`=0 after the edge; saturates at all-ones; cleared only by reset (not by flush).
- Entries leave in arrival order; no entry is duplicated or lost except by flush.

## Timing
- Reset (asynchronous, immediate): `out_valid`=0, `adder_out`=0, `instruction_out`=`NOP_INSTR`, skid entry empty, `in_ready`=1, `bubble_cnt`=0.
- Latency: an accepted entry appears on outputs one cycle after the accept edge.
- Throughput: one entry per cycle when `stall`=0.
- Reset mid-operation: all entries discarded, counter cleared, same values as above.
- Stall and flush in the same cycle: flush wins, stage empties.

## Configuration
- `IFID_SKID_EN` defined: second (skid) entry. `in_ready` = !skid_valid (registered, no path from `stall`). Accept while main held and not consumed loads skid. On consume with skid valid, skid moves to main the same edge. Accept is impossible while skid valid.
- Not defined: single entry. `in_ready` = !`out_valid` | !`stall` (combinational). Skid storage and logic are absent.

## Structure
- Shared package `ifid_pkg`: the `NOP_INSTR` default constant and an entry typedef (pc, instr, valid) used by main and skid registers.
- One sub-module is natural: `sat_counter`, which implements the saturating bubble counter with `CNT_W` and an increment enable.

## Test plan
- Reset held 10 ns, then released -> `out_valid`=0, `instruction_out`=`NOP_INSTR`, `in_ready`=1, `bubble_cnt` counts from 0 each cycle.
- `adder_in`=2, `instruction_in`=3, `in_valid`=1, `hit`=1, `stall`=0 -> next cycle `adder_out`=2, `instruction_out`=3, `out_valid`=1.
- Same inputs with `hit`=0 (`adder_in`=200, `instruction_in`=300) -> outputs unchanged from the prior valid entry or empty; 200/300 never appear.
- Entry A held with `stall`=1, present B -> skid build: B stored, `in_ready`=0, then `stall`=0 delivers A then B on consecutive cycles. Non-skid build: `in_ready`=0, B not taken.
- `flush`=1 with two held entries and a new accept in the same cycle -> next cycle `out_valid`=0, `instruction_out`=`NOP_INSTR`, `in_ready`=1, and the new entry is dropped.
- `CNT_W`=4, idle 20 cycles -> `bubble_cnt` stops at 15; assert `rstn` mid-run -> all outputs return to their reset values immediately.
